fila_arbiter: RTL

FILA_ARBITER -- requirements
Module: fila_arbiter

---
 rtl/fila_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/fila_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fila_pkg.sv
// Shared constants and FSM state type for the two-producer queue arbiter.
package fila_pkg;
    localparam int FILA_DEPTH = 8;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENQ    = 2'd1,
        DEQ    = 2'd2,
        SETTLE = 2'd3
    } fila_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector; the priority pointer moves past the winner only when advanced.
module rr_arbiter2 (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    // r_ptr = 0: requester 0 (A) has priority
    logic r_ptr;

    always_comb begin
        grant = 2'b00;
        if (r_ptr == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            r_ptr <= grant[0];
        end
    end
endmodule

// File: rtl/fila_arbiter.sv
// Arbitrates two enqueue producers and one dequeue consumer onto a single queue,
// issuing one registered command per IDLE->cmd->SETTLE sequence.
module fila_arbiter
    import fila_pkg::*;
#(
    parameter int DEPTH = FILA_DEPTH
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              deq_req,
    input  logic              clr_err,
    input  logic [7:0]        len_in,
    input  logic [DATA_W-1:0] q_data_in,
    output logic              enqueue_out,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_to_q,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              deq_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);
    fila_state_t       r_state;
    fila_state_t       w_state_next;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_rr_req;
    logic [1:0]        w_rr_grant;
    logic              w_elig_enq;
    logic              w_elig_deq;
    logic              w_do_enq;
    logic              w_do_deq;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              r_last_deq;
    logic              r_enq_out;
    logic              r_deq_out;
    logic              r_gnt_a;
    logic              r_gnt_b;
    logic              r_deq_gnt;
    logic [DATA_W-1:0] r_data_to_q;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf_err;
    logic              r_unf_err;

    assign w_full     = (len_in == 8'(DEPTH));
    assign w_empty    = (len_in == 8'd0);
    assign w_rr_req   = {req_b & ~w_full, req_a & ~w_full};
    assign w_elig_enq = |w_rr_req;
    assign w_elig_deq = deq_req & ~w_empty;
    assign w_ovf_set  = (r_state == IDLE) && (req_a || req_b) && w_full;
    assign w_unf_set  = (r_state == IDLE) && deq_req && w_empty;

    rr_arbiter2 u_rr (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .req       (w_rr_req),
        .advance   (w_do_enq),
        .grant     (w_rr_grant)
    );

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // When both kinds are eligible, the op opposite to the last one wins
    always_comb begin
        w_state_next = r_state;
        w_do_enq     = 1'b0;
        w_do_deq     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig_enq && (!w_elig_deq || r_last_deq)) begin
                    w_do_enq     = 1'b1;
                    w_state_next = ENQ;
                end else if (w_elig_deq) begin
                    w_do_deq     = 1'b1;
                    w_state_next = DEQ;
                end
            end
            ENQ, DEQ: w_state_next = SETTLE;
            SETTLE:   w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            r_last_deq  <= 1'b1;
            r_enq_out   <= 1'b0;
            r_deq_out   <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_deq_gnt   <= 1'b0;
            r_data_to_q <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
        end else begin
            r_enq_out  <= w_do_enq;
            r_gnt_a    <= w_do_enq & w_rr_grant[0];
            r_gnt_b    <= w_do_enq & w_rr_grant[1];
            r_deq_out  <= w_do_deq;
            r_deq_gnt  <= w_do_deq;
            if (w_do_enq) begin
                r_data_to_q <= w_rr_grant[1] ? data_b : data_a;
                r_last_deq  <= 1'b0;
            end else if (w_do_deq) begin
                r_last_deq  <= 1'b1;
            end
            // Head data is stable from the queue by the SETTLE cycle after a dequeue
            r_rd_valid <= (r_state == SETTLE) && r_last_deq;
            if ((r_state == SETTLE) && r_last_deq) begin
                r_rd_data <= q_data_in;
            end
            r_ovf_err <= w_ovf_set | (r_ovf_err & ~clr_err);
            r_unf_err <= w_unf_set | (r_unf_err & ~clr_err);
        end
    end

    assign enqueue_out = r_enq_out;
    assign dequeue_out = r_deq_out;
    assign data_to_q   = r_data_to_q;
    assign gnt_a       = r_gnt_a;
    assign gnt_b       = r_gnt_b;
    assign deq_gnt     = r_deq_gnt;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign full        = w_full;
    assign empty       = w_empty;
    assign ovf_err     = r_ovf_err;
    assign unf_err     = r_unf_err;
endmodule
